spi_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter sharing the single register port of the `spi_top` SPI master between the flash XIP sequencer (master 0) and direct CPU register access from APB (master 1). It grants one master at a time and routes ack and read data back only to the granted master. A lock input keeps the grant across the multi-register XIP sequence (TX1, DIVIDER, SS, CTRL, poll, RX0, SS clear), so CPU accesses cannot interleave. A lock-hold timeout stops a stuck master from owning the SPI controller forever.

---
 rtl/spi_arb_pkg.sv | 22 ++
 rtl/spi_arb_lock_timer.sv | 31 +++
 rtl/spi_wb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_spi_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI Wishbone arbiter
package spi_arb_pkg;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // One-hot grant encodings presented on the grant port
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Values driven onto the slave bus when nobody is actively using it
  localparam logic        IDLE_CTL = 1'b0;
  localparam logic [4:0]  IDLE_ADR = 5'd0;
  localparam logic [31:0] IDLE_DAT = 32'd0;
  localparam logic [3:0]  IDLE_SEL = 4'd0;

endpackage

// File: rtl/spi_arb_lock_timer.sv
// rtl/spi_arb_lock_timer.sv - counts locked-idle cycles and flags a stuck lock owner
module spi_arb_lock_timer #(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(LOCK_TIMEOUT - 1);

  logic [TO_W-1:0] count;

  // Count locked-idle cycles; clear has priority so a release restarts from zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + TO_W'(1);
    end
  end

  // Expiry fires on the cycle whose closing edge would make the count reach LOCK_TIMEOUT
  assign expired = count_en && (count == LAST_CNT);

endmodule

// File: rtl/spi_wb_arbiter.sv
// rtl/spi_wb_arbiter.sv - two-master Wishbone arbiter in front of the spi_top register port
module spi_wb_arbiter
  import spi_arb_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [4:0]  m0_adr,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [4:0]  m1_adr,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [4:0]  s_adr,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  input  logic        s_err,
  output logic [1:0]  grant,
  output logic        lock_to
);

  arb_state_t state;
  logic       last_m1;
  logic       req0;
  logic       req1;
  logic       owner_cyc;
  logic       owner_lock;
  logic       locked_idle;
  logic       expired;
  logic       rel;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  // Select the current owner's cyc/lock so release and timer logic are state-agnostic
  always_comb begin
    owner_cyc  = 1'b0;
    owner_lock = 1'b0;
    case (state)
      GNT0: begin
        owner_cyc  = m0_cyc;
        owner_lock = m0_lock;
      end
      GNT1: begin
        owner_cyc  = m1_cyc;
        owner_lock = m1_lock;
      end
      default: begin
        owner_cyc  = 1'b0;
        owner_lock = 1'b0;
      end
    endcase
  end

  // Owner holds the bus between transfers only by lock; release needs cyc low, so an active cycle is never cut
  assign locked_idle = (state != IDLE) && !owner_cyc && owner_lock;
  assign rel         = (state != IDLE) && !owner_cyc && (!owner_lock || expired);

  spi_arb_lock_timer #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .TO_W         (TO_W)
  ) u_lock_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (!locked_idle || rel),
    .count_en (locked_idle),
    .expired  (expired)
  );

  // Ownership FSM with registered grant, round-robin tie memory and sticky timeout flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= GRANT_NONE;
      last_m1 <= 1'b1;
      lock_to <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_m1)) begin
            state   <= GNT0;
            grant   <= GRANT_M0;
            last_m1 <= 1'b0;
          end else if (req1) begin
            state   <= GNT1;
            grant   <= GRANT_M1;
            last_m1 <= 1'b1;
          end
        end
        GNT0: begin
          if (rel) begin
            if (expired) lock_to <= 1'b1;
            if (req1) begin
              state   <= GNT1;
              grant   <= GRANT_M1;
              last_m1 <= 1'b1;
            end else begin
              state <= IDLE;
              grant <= GRANT_NONE;
            end
          end
        end
        GNT1: begin
          if (rel) begin
            if (expired) lock_to <= 1'b1;
            if (req0) begin
              state   <= GNT0;
              grant   <= GRANT_M0;
              last_m1 <= 1'b0;
            end else begin
              state <= IDLE;
              grant <= GRANT_NONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

  // Route the owner onto the slave bus and the slave responses back to the owner only
  always_comb begin
    s_cyc    = IDLE_CTL;
    s_stb    = IDLE_CTL;
    s_we     = IDLE_CTL;
    s_adr    = IDLE_ADR;
    s_dat_o  = IDLE_DAT;
    s_sel    = IDLE_SEL;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_o = IDLE_DAT;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_o = IDLE_DAT;
    case (state)
      GNT0: begin
        if (!locked_idle) begin
          s_cyc   = m0_cyc;
          s_stb   = m0_stb;
          s_we    = m0_we;
          s_adr   = m0_adr;
          s_dat_o = m0_dat_i;
          s_sel   = m0_sel;
        end
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_dat_o = s_dat_i;
      end
      GNT1: begin
        if (!locked_idle) begin
          s_cyc   = m1_cyc;
          s_stb   = m1_stb;
          s_we    = m1_we;
          s_adr   = m1_adr;
          s_dat_o = m1_dat_i;
          s_sel   = m1_sel;
        end
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_dat_o = s_dat_i;
      end
      default: begin
        s_cyc = IDLE_CTL;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// tb/tb_spi_wb_arbiter.sv - self-checking bench for spi_wb_arbiter
module tb_spi_wb_arbiter;

  localparam int LT = 8;
  localparam int TW = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mcyc, mstb, mwe, mlock;
  logic [4:0]  madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [4:0]  s_adr;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_i;
  logic        s_ack, s_err;
  logic [1:0]  grant;
  logic        lock_to;

  logic [1:0]  ackv, errv;
  logic [31:0] datv [2];
  assign ackv    = {m1_ack, m0_ack};
  assign errv    = {m1_err, m0_err};
  assign datv[0] = m0_dat_o;
  assign datv[1] = m1_dat_o;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_n       = 0;
  int last_granted;
  int scnt;

  spi_wb_arbiter #(.LOCK_TIMEOUT(LT), .TO_W(TW)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_lock(mlock[0]),
    .m0_adr(madr[0]), .m0_dat_i(mdat[0]), .m0_sel(msel[0]),
    .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_lock(mlock[1]),
    .m1_adr(madr[1]), .m1_dat_i(mdat[1]), .m1_sel(msel[1]),
    .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_sel(s_sel), .s_dat_i(s_dat_i),
    .s_ack(s_ack), .s_err(s_err), .grant(grant), .lock_to(lock_to)
  );

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc_n++; end

  function automatic logic [31:0] slave_rd(input logic [4:0] a);
    return {16'hC0DE, 11'h000, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // spi_top model: responds two cycles after it first sees a strobe, err for adr 0x1F
  initial begin
    s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0; scnt = 0;
    forever begin
      @(posedge clock); #2;
      if (reset) begin
        s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0; scnt = 0;
      end else if (s_ack || s_err) begin
        s_ack = 1'b0; s_err = 1'b0; scnt = 0;
      end else if (s_cyc && s_stb) begin
        scnt++;
        if (scnt == 2) begin
          if (s_adr == 5'h1F) s_err = 1'b1; else s_ack = 1'b1;
          s_dat_i = slave_rd(s_adr);
        end
      end else begin
        scnt = 0;
      end
    end
  end

  // Routing rules checked every cycle away from the active edge
  task automatic monitor();
    int o, n;
    chk("grant_legal", 32'(grant != 2'b11), 32'd1);
    if (grant == 2'b00) begin
      chk("idle_s_cyc", 32'(s_cyc), 32'd0);
      chk("idle_resp", 32'({m1_ack, m0_ack, m1_err, m0_err}), 32'd0);
    end else if (grant != 2'b11) begin
      o = grant[1] ? 1 : 0;
      n = 1 - o;
      chk("own_ack", 32'(ackv[o]), 32'(s_ack));
      chk("own_err", 32'(errv[o]), 32'(s_err));
      chk("own_dat", datv[o], s_dat_i);
      chk("oth_resp", 32'({ackv[n], errv[n]}), 32'd0);
      chk("oth_dat", datv[n], 32'd0);
      if (!mcyc[o] && mlock[o]) begin
        chk("lockidle_bus", 32'({s_cyc, s_stb, s_we, s_adr, s_sel}), 32'd0);
        chk("lockidle_dat", s_dat_o, 32'd0);
      end else begin
        chk("fwd_ctl", 32'({s_cyc, s_stb, s_we}), 32'({mcyc[o], mstb[o], mwe[o]}));
        chk("fwd_adr", 32'({s_sel, s_adr}), 32'({msel[o], madr[o]}));
        chk("fwd_dat", s_dat_o, mdat[o]);
      end
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (!reset) monitor();
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic xfer(input int m, input logic [4:0] adr, input logic [31:0] dat,
                      input logic we, input logic keep_lock, input int budget,
                      output int req_c, output int gnt_c, output int ack_c,
                      output logic [31:0] rd, output logic er);
    gnt_c = -1; ack_c = -1; rd = '0; er = 1'b0;
    @(posedge clock); #1;
    mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = we; madr[m] = adr;
    mdat[m] = dat; msel[m] = 4'hF; mlock[m] = keep_lock;
    req_c = cyc_n;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (gnt_c < 0 && grant[m]) gnt_c = cyc_n;
      if (ackv[m] || errv[m]) begin
        ack_c = cyc_n; rd = datv[m]; er = errv[m];
        break;
      end
    end
    chk($sformatf("m%0d_resp_seen", m), 32'(ack_c >= 0), 32'd1);
    @(posedge clock); #1;
    mcyc[m] = 1'b0; mstb[m] = 1'b0; mwe[m] = 1'b0;
    madr[m] = '0; mdat[m] = '0; msel[m] = '0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    last_granted = 1;
  endtask

  task automatic do_tie(input string tag);
    int r0, g0, a0, r1, g1, a1, w, exp_w;
    logic [31:0] d0, d1;
    logic e0, e1;
    exp_w = (last_granted == 0) ? 1 : 0;
    fork
      xfer(0, 5'h02, $urandom, 1'b0, 1'b0, 100, r0, g0, a0, d0, e0);
      xfer(1, 5'h03, $urandom, 1'b0, 1'b0, 100, r1, g1, a1, d1, e1);
    join
    w = (g0 >= 0 && (g1 < 0 || g0 < g1)) ? 0 : 1;
    chk({tag, "_winner"}, 32'(w), 32'(exp_w));
    chk({tag, "_win_lat"}, 32'((w == 0) ? g0 - r0 : g1 - r1), 32'd1);
    chk({tag, "_handover"}, 32'((w == 0) ? g1 : g0), 32'(((w == 0) ? a0 : a1) + 2));
    last_granted = 1 - w;
  endtask

  initial begin
    int r, g, a, r1, g1, a1, drop_c, idle, solo;
    logic [31:0] d, d1;
    logic e, e1, lt_pre, seen;
    logic [4:0] ra;
    mcyc = '0; mstb = '0; mwe = '0; mlock = '0;
    for (int i = 0; i < 2; i++) begin madr[i] = '0; mdat[i] = '0; msel[i] = '0; end
    last_granted = 1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_lock_to", 32'(lock_to), 32'd0);
    chk("rst_s_bus", 32'({s_cyc, s_stb, s_we, s_adr, s_sel}), 32'd0);
    chk("rst_resp", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    // Master 0 alone
    xfer(0, 5'h04, 32'h0300_0010, 1'b1, 1'b0, 20, r, g, a, d, e);
    chk("m0_gnt_lat", 32'(g - r), 32'd1);
    chk("m0_rdata", d, slave_rd(5'h04));
    chk("m0_err", 32'(e), 32'd0);
    last_granted = 0;

    // Simultaneous requests from reset, then alternation over further ties
    do_reset();
    do_tie("tie0");
    for (int t = 1; t < 5; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        solo = $urandom_range(0, 1);
        xfer(solo, 5'h09, $urandom, 1'b1, 1'b0, 20, r, g, a, d, e);
        last_granted = solo;
      end
      do_tie($sformatf("tie%0d", t));
    end

    // Lock hold across 7 transfers while master 1 waits
    fork
      begin
        for (int k = 0; k < 7; k++) begin
          xfer(0, 5'($urandom_range(0, 30)), $urandom, 1'b1, 1'b1, 20, r, g, a, d, e);
          repeat (3) @(posedge clock);
        end
        @(posedge clock); #1 mlock[0] = 1'b0;
        drop_c = cyc_n;
      end
      begin
        @(posedge clock);
        xfer(1, 5'h05, 32'hAAAA_5555, 1'b1, 1'b0, 400, r1, g1, a1, d1, e1);
      end
    join
    chk("lock_m1_gnt", 32'(g1), 32'(drop_c + 1));
    chk("lock_m1_ack_after", 32'(a1 > drop_c), 32'd1);

    // Lock timeout with master 0 idling under lock
    idle = 0; lt_pre = 1'b1;
    fork
      begin
        xfer(0, 5'h06, 32'h0000_0006, 1'b1, 1'b1, 20, r, g, a, d, e);
        for (int i = 0; i < 40; i++) begin
          @(negedge clock);
          if (grant == 2'b01 && !mcyc[0]) begin
            idle++;
            lt_pre = lock_to;
          end else break;
        end
        chk("to_idle_cycles", 32'(idle), 32'(LT));
        chk("to_flag_before", 32'(lt_pre), 32'd0);
        chk("to_flag_set", 32'(lock_to), 32'd1);
        chk("to_m1_granted", 32'(grant), 32'd2);
      end
      begin
        @(posedge clock);
        xfer(1, 5'h07, 32'h0000_0007, 1'b1, 1'b0, 200, r1, g1, a1, d1, e1);
      end
    join
    @(posedge clock); #1 mlock[0] = 1'b0;
    xfer(0, 5'h0A, 32'h0000_000A, 1'b1, 1'b0, 20, r, g, a, d, e);
    chk("to_flag_sticky", 32'(lock_to), 32'd1);
    do_reset();
    @(negedge clock);
    chk("to_flag_cleared", 32'(lock_to), 32'd0);

    // Reset while master 1 owns an active cycle
    @(posedge clock); #1;
    mcyc[1] = 1'b1; mstb[1] = 1'b1; mwe[1] = 1'b1; madr[1] = 5'h08;
    mdat[1] = 32'h1234_5678; msel[1] = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (grant == 2'b10 && s_cyc) begin seen = 1'b1; break; end
    end
    chk("rst_mid_owned", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_grant", 32'(grant), 32'd0);
    chk("rst_async_s", 32'({s_cyc, s_stb}), 32'd0);
    chk("rst_async_ack", 32'(m1_ack), 32'd0);
    mcyc[1] = 1'b0; mstb[1] = 1'b0; mwe[1] = 1'b0; madr[1] = '0; mdat[1] = '0; msel[1] = '0;
    @(posedge clock); #1 reset = 1'b0;
    last_granted = 1;
    do_tie("post_rst");

    // Error passthrough to master 1
    xfer(1, 5'h1F, 32'h0, 1'b0, 1'b0, 20, r, g, a, d, e);
    chk("err_m1", 32'(e), 32'd1);

    // Random concurrent traffic from both masters
    fork
      for (int k = 0; k < 12; k++) begin
        logic [4:0] ad; int rr, gg, aa; logic [31:0] dd; logic ee;
        repeat ($urandom_range(0, 3)) @(posedge clock);
        ad = 5'($urandom_range(0, 31));
        xfer(0, ad, $urandom, 1'($urandom_range(0, 1)), 1'b0, 60, rr, gg, aa, dd, ee);
        chk("rnd_m0_dat", dd, slave_rd(ad));
        chk("rnd_m0_err", 32'(ee), 32'(ad == 5'h1F));
      end
      for (int k = 0; k < 12; k++) begin
        logic [4:0] ad; int rr, gg, aa; logic [31:0] dd; logic ee;
        repeat ($urandom_range(0, 3)) @(posedge clock);
        ad = 5'($urandom_range(0, 31));
        xfer(1, ad, $urandom, 1'($urandom_range(0, 1)), 1'b0, 60, rr, gg, aa, dd, ee);
        chk("rnd_m1_dat", dd, slave_rd(ad));
        chk("rnd_m1_err", 32'(ee), 32'(ad == 5'h1F));
      end
    join
    ra = 5'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("end_idle_grant", 32'(grant), 32'(ra));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
